// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler that time-multiplexes one shared hex-to-BCD converter
// across NCH binary watch fields and keeps the latest BCD result per channel.
module bcd_conv_sched #(
  parameter int NCH        = 3,
  parameter int START_HOLD = 3,
  parameter int GAP        = 2,
  parameter int TIMEOUT    = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req,
  input  logic [7*NCH-1:0]   din,
  output logic               conv_start,
  output logic [6:0]         conv_din,
  input  logic               conv_done,
  input  logic [3:0]         conv_bcd_h,
  input  logic [3:0]         conv_bcd_l,
  output logic [8*NCH-1:0]   bcd_out,
  output logic               upd_valid,
  output logic [2:0]         upd_ch,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t         state;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] pend_clr;
  logic [2:0]     rr;
  logic [2:0]     cur;
  logic [2:0]     gnt;
  logic [6:0]     gnt_din;
  logic [4:0]     cnt;
  logic           timeout_hit;

  // Pending channel with the smallest forward distance from the rr pointer.
  function automatic logic [2:0] pick(input logic [NCH-1:0] p, input logic [2:0] start);
    logic [2:0] best;
    int         best_d;
    int         d;
    best   = start;
    best_d = NCH;
    for (int i = 0; i < NCH; i++) begin
      d = (i + NCH - int'(start)) % NCH;
      if (p[i] && d < best_d) begin
        best   = 3'(i);
        best_d = d;
      end
    end
    return best;
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = pick(pend, rr);
    gnt_din = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt == 3'(i)) gnt_din = din[7*i +: 7];
    end
  end

  assign timeout_hit = (state == S_WAIT) && !conv_done && (cnt == 5'(TIMEOUT - 1));

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur == 3'(i) && (state == S_CAPTURE || timeout_hit)) pend_clr[i] = 1'b1;
    end
  end

  assign busy = (state != S_IDLE);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pend       <= '0;
      rr         <= '0;
      cur        <= '0;
      cnt        <= '0;
      conv_start <= 1'b0;
      conv_din   <= '0;
      bcd_out    <= '0;
      upd_valid  <= 1'b0;
      upd_ch     <= '0;
      err        <= 1'b0;
    end else begin
      upd_valid <= 1'b0;
      err       <= 1'b0;
      // A new request in the same cycle as a clear re-arms the channel.
      pend      <= (pend & ~pend_clr) | req;

      case (state)
        S_IDLE: begin
          if (|pend) begin
            cur        <= gnt;
            conv_din   <= gnt_din;
            conv_start <= 1'b1;
            cnt        <= '0;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (cnt == 5'(START_HOLD - 1)) begin
            conv_start <= 1'b0;
            cnt        <= '0;
            state      <= S_WAIT;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        S_WAIT: begin
          if (conv_done) begin
            state <= S_CAPTURE;
          end else if (timeout_hit) begin
            err    <= 1'b1;
            upd_ch <= cur;
            cnt    <= '0;
            state  <= S_DRAIN;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        S_CAPTURE: begin
          for (int i = 0; i < NCH; i++) begin
            if (cur == 3'(i)) bcd_out[8*i +: 8] <= {conv_bcd_h, conv_bcd_l};
          end
          upd_valid <= 1'b1;
          upd_ch    <= cur;
          rr        <= (cur == 3'(NCH - 1)) ? 3'd0 : cur + 3'd1;
          cnt       <= '0;
          state     <= S_DRAIN;
        end

        S_DRAIN: begin
          // The gap count restarts while done is still high, so it measures from done falling.
          if (conv_done) begin
            cnt <= '0;
          end else if (cnt == 5'(GAP - 1)) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: behavioural converter, event monitor and a
// channel-level reference model of the round-robin schedule and BCD results.
module tb_bcd_conv_sched;
  localparam int NCH        = 3;
  localparam int START_HOLD = 3;
  localparam int GAP        = 2;
  localparam int TIMEOUT    = 31;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NCH-1:0]     req = '0;
  logic [7*NCH-1:0]   din = '0;
  logic               conv_start;
  logic [6:0]         conv_din;
  logic               conv_done = 1'b0;
  logic [3:0]         conv_bcd_h = '0;
  logic [3:0]         conv_bcd_l = '0;
  logic [8*NCH-1:0]   bcd_out;
  logic               upd_valid;
  logic [2:0]         upd_ch;
  logic               busy;
  logic               err;

  int errors = 0;
  int checks = 0;

  bcd_conv_sched #(
    .NCH(NCH), .START_HOLD(START_HOLD), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .conv_start(conv_start), .conv_din(conv_din), .conv_done(conv_done),
    .conv_bcd_h(conv_bcd_h), .conv_bcd_l(conv_bcd_l),
    .bcd_out(bcd_out), .upd_valid(upd_valid), .upd_ch(upd_ch),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Behavioural converter: acts on a start rising edge, raises done after cv_lat cycles for cv_hold cycles.
  bit         cv_dead  = 1'b0;
  int         cv_lat   = 5;
  int         cv_hold  = 3;
  int         cv_timer = 0;
  int         cv_left  = 0;
  logic [6:0] cv_val   = '0;
  logic       start_q  = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      cv_timer  <= 0;
      cv_left   <= 0;
      conv_done <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q <= conv_start;
      if (cv_timer == 1) begin
        conv_done                <= 1'b1;
        {conv_bcd_h, conv_bcd_l} <= to_bcd(int'(cv_val));
        cv_left                  <= cv_hold;
      end else if (cv_left > 0) begin
        if (cv_left == 1) conv_done <= 1'b0;
        cv_left <= cv_left - 1;
      end
      if (cv_timer > 0) cv_timer <= cv_timer - 1;
      if (conv_start && !start_q && !cv_dead) begin
        cv_val   <= conv_din;
        cv_timer <= cv_lat;
      end
    end
  end

  // Monitor sampled on the falling edge.
  int         cyc = 0;
  int         ch_q[$];
  int         rises = 0, bad_width = 0, bad_valid = 0, err_pulses = 0;
  int         hi_run = 0, lo_done = 1000, min_gap = 1000, v_run = 0;
  int         fall_cyc = 0, err_cyc = 0;
  logic [6:0] start_din = '0;
  logic [2:0] err_ch = '0;
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      hi_run     = 0;
      lo_done    = 1000;
      prev_start = 1'b0;
      v_run      = 0;
    end else begin
      if (conv_start && !prev_start) begin
        rises++;
        start_din = conv_din;
        if (lo_done < min_gap) min_gap = lo_done;
      end
      if (!conv_start && prev_start) begin
        fall_cyc = cyc;
        if (hi_run != START_HOLD) bad_width++;
      end
      hi_run     = conv_start ? hi_run + 1 : 0;
      prev_start = conv_start;
      lo_done    = conv_done ? 0 : lo_done + 1;
      if (upd_valid) begin
        ch_q.push_back(int'(upd_ch));
        v_run++;
        if (v_run > 1) bad_valid++;
      end else begin
        v_run = 0;
      end
      if (err) begin
        err_pulses++;
        err_cyc = cyc;
        err_ch  = upd_ch;
      end
    end
  end

  // Reference model: expected per-channel BCD and the round-robin pointer.
  logic [7:0] exp_b [NCH];
  int         model_rr = 0;

  function automatic logic [8*NCH-1:0] exp_vec();
    logic [8*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[8*i +: 8] = exp_b[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_din(input int ch, input int val);
    din[7*ch +: 7] = 7'(val);
  endtask

  function automatic int get_din(input int ch);
    return int'(din[7*ch +: 7]);
  endfunction

  task automatic pulse_req(input logic [NCH-1:0] m);
    req = m;
    step(1);
    req = '0;
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0;
    int n = 0;
    while (q < 12 && n < 3000) begin
      step(1);
      n++;
      q = busy ? 0 : q + 1;
    end
    check({tag, "_quiet"}, 64'(q >= 12), 64'(1));
  endtask

  task automatic wait_updates(input string tag, input int n);
    int k = 0;
    while (ch_q.size() < n && k < 400) begin
      step(1);
      k++;
    end
    check({tag, "_upd_cnt"}, 64'(ch_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    for (int i = 0; i < NCH; i++) exp_b[i] = '0;
    model_rr = 0;
    ch_q.delete();
  endtask

  initial begin
    int r0, e0, k, idx, zb, nexp, seq_o, seq_e, last;
    logic [NCH-1:0] m;
    logic [6:0] v;
    for (int i = 0; i < NCH; i++) exp_b[i] = '0;

    // Reset state
    step(3);
    check("rst_bcd_out", 64'(bcd_out), 64'(0));
    check("rst_conv_start", 64'(conv_start), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_flags", 64'({upd_valid, err, upd_ch, conv_din}), 64'(0));
    rst = 1'b1;
    step(2);

    // 1: single request on ch1; din changes after grant are ignored
    for (int i = 0; i < NCH; i++) set_din(i, int'($urandom_range(0, 99)));
    set_din(1, 47);
    r0 = rises;
    pulse_req(3'b010);
    k = 0;
    while (rises == r0 && k < 50) begin step(1); k++; end
    check("t1_start_seen", 64'(rises - r0), 64'(1));
    set_din(1, 88);
    wait_updates("t1", 1);
    check("t1_conv_din", 64'(start_din), 64'(47));
    check("t1_upd_ch", 64'(ch_q.size() > 0 ? ch_q[0] : -1), 64'(1));
    exp_b[1] = to_bcd(47);
    model_rr = 2;
    check("t1_bcd_out", 64'(bcd_out), 64'(exp_vec()));
    wait_quiet("t1");
    check("t1_one_start", 64'(rises - r0), 64'(1));

    // 2: all three at once from a fresh reset
    do_reset();
    set_din(0, 5); set_din(1, 59); set_din(2, 23);
    pulse_req(3'b111);
    wait_updates("t2", 3);
    seq_o = 0;
    foreach (ch_q[i]) seq_o = seq_o * 10 + ch_q[i];
    check("t2_order", 64'(seq_o), 64'(12));
    for (int i = 0; i < NCH; i++) exp_b[i] = to_bcd(get_din(i));
    model_rr = 0;
    check("t2_bcd_out", 64'(bcd_out), 64'(24'h235905));
    wait_quiet("t2");
    check("t2_exact3", 64'(ch_q.size()), 64'(3));

    // 3: fairness with ch0 held high and a single ch2 pulse
    ch_q.delete();
    for (int i = 0; i < NCH; i++) set_din(i, int'($urandom_range(0, 99)));
    req = 3'b001;
    step(1);
    req = 3'b101;
    step(1);
    req = 3'b001;
    k = 0;
    idx = -1;
    while (idx < 0 && k < 400) begin
      step(1);
      k++;
      foreach (ch_q[i]) if (ch_q[i] == 2 && idx < 0) idx = i;
    end
    check("t3_ch2_served", 64'(idx >= 0), 64'(1));
    zb = 0;
    for (int i = 0; i < idx; i++) if (ch_q[i] == 0) zb++;
    check("t3_ch0_before_ch2", 64'(zb <= 1), 64'(1));
    req = '0;
    wait_quiet("t3");
    exp_b[0] = to_bcd(get_din(0));
    exp_b[2] = to_bcd(get_din(2));
    check("t3_bcd_out", 64'(bcd_out), 64'(exp_vec()));

    // 4: converter never answers
    cv_dead = 1'b1;
    ch_q.delete();
    e0 = err_pulses;
    r0 = rises;
    set_din(1, int'($urandom_range(0, 99)));
    pulse_req(3'b010);
    k = 0;
    while (err_pulses == e0 && k < 200) begin step(1); k++; end
    check("t4_err_pulse", 64'(err_pulses - e0), 64'(1));
    check("t4_err_delay", 64'(err_cyc - fall_cyc), 64'(TIMEOUT));
    check("t4_err_ch", 64'(err_ch), 64'(1));
    check("t4_no_upd", 64'(ch_q.size()), 64'(0));
    check("t4_bcd_kept", 64'(bcd_out), 64'(exp_vec()));
    step(60);
    check("t4_idle_after", 64'(busy), 64'(0));
    check("t4_no_retry", 64'(rises - r0), 64'(1));
    cv_dead = 1'b0;
    pulse_req(3'b010);
    wait_updates("t4_retry", 1);
    check("t4_retry_ch", 64'(ch_q.size() > 0 ? ch_q[0] : -1), 64'(1));
    exp_b[1] = to_bcd(get_din(1));
    model_rr = 2;
    check("t4_retry_bcd", 64'(bcd_out), 64'(exp_vec()));
    wait_quiet("t4");

    // 5: random back-to-back rounds, including values above 99
    r0 = rises;
    nexp = 0;
    for (int r = 0; r < 8; r++) begin
      cv_lat  = int'($urandom_range(3, 10));
      cv_hold = int'($urandom_range(2, 5));
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int i = 0; i < NCH; i++) set_din(i, int'($urandom_range(0, 127)));
      ch_q.delete();
      pulse_req(m);
      wait_quiet("t5");
      seq_e = 0;
      last = model_rr;
      for (int j = 0; j < NCH; j++) begin
        int c;
        c = (model_rr + j) % NCH;
        if (m[c]) begin
          seq_e = seq_e * 10 + c;
          exp_b[c] = to_bcd(get_din(c));
          last = c;
          nexp++;
        end
      end
      model_rr = (last + 1) % NCH;
      seq_o = 0;
      foreach (ch_q[i]) seq_o = seq_o * 10 + ch_q[i];
      check("t5_order", 64'({32'(ch_q.size()), 32'(seq_o)}), 64'({32'($countones(m)), 32'(seq_e)}));
      check("t5_bcd_out", 64'(bcd_out), 64'(exp_vec()));
    end
    check("t5_one_edge_per_conv", 64'(rises - r0), 64'(nexp));
    check("t5_min_gap", 64'(min_gap >= GAP + 1), 64'(1));
    check("start_width_ok", 64'(bad_width), 64'(0));
    check("upd_valid_1cycle", 64'(bad_valid), 64'(0));

    // 6: asynchronous reset in the middle of WAIT
    cv_lat = 25;
    cv_hold = 3;
    v = 7'($urandom_range(0, 99));
    set_din(2, int'(v));
    r0 = rises;
    pulse_req(3'b100);
    k = 0;
    while (rises == r0 && k < 50) begin step(1); k++; end
    step(START_HOLD + 4);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_start", 64'(conv_start), 64'(0));
    check("t6_async_busy", 64'(busy), 64'(0));
    check("t6_async_bcd", 64'(bcd_out), 64'(0));
    step(2);
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) exp_b[i] = '0;
    model_rr = 0;
    cv_lat = 5;
    ch_q.delete();
    step(1);
    pulse_req(3'b100);
    wait_updates("t6", 1);
    check("t6_ch", 64'(ch_q.size() > 0 ? ch_q[0] : -1), 64'(2));
    exp_b[2] = to_bcd(int'(v));
    check("t6_bcd_out", 64'(bcd_out), 64'(exp_vec()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
